// File: rtl/modn_period_ctrl.sv
// Run controller for a programmable mod-N counter. Keeps a validated modulus in
// a shadow register and commits it to the live counter only at run start or at
// a wrap boundary, so a period is never cut short or stretched mid-count.
module modn_period_ctrl #(
    parameter int unsigned W           = 6,
    parameter int unsigned PW          = 8,
    parameter int unsigned DEFAULT_MOD = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  cfg_modN,
    input  logic [PW-1:0] cfg_periods,
    input  logic          cfg_wr,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic [W-1:0]  count,
    output logic [W-1:0]  active_mod,
    output logic [PW-1:0] period_cnt,
    output logic          tc,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [W-1:0] ModReset = W'(DEFAULT_MOD);
    localparam logic [W-1:0] MinMod   = W'(2);

    state_e        state_q;
    logic [W-1:0]  shadow_q;
    logic          pending_q;
    logic [PW-1:0] periods_lat_q;

    logic          cfg_ok;
    logic [W-1:0]  next_mod;
    logic [PW-1:0] period_inc;
    logic          last_period;

    // A write in the commit cycle itself takes effect without waiting a cycle
    // for the shadow register to catch up.
    always_comb begin
        cfg_ok      = cfg_wr && (cfg_modN >= MinMod);
        next_mod    = cfg_ok ? cfg_modN : shadow_q;
        period_inc  = period_cnt + 1'b1;
        last_period = (periods_lat_q != '0) && (period_inc == periods_lat_q);
        tc          = (state_q == StRun) && (count == active_mod - 1'b1);
    end

    // Run FSM with registered outputs; stop outranks everything in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            shadow_q      <= ModReset;
            pending_q     <= 1'b0;
            periods_lat_q <= '0;
            busy          <= 1'b0;
            count         <= '0;
            active_mod    <= ModReset;
            period_cnt    <= '0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= cfg_wr && !cfg_ok;
            if (cfg_ok) begin
                shadow_q <= cfg_modN;
            end

            case (state_q)
                StIdle: begin
                    count <= '0;
                    if (start && !stop) begin
                        state_q       <= StRun;
                        busy          <= 1'b1;
                        active_mod    <= next_mod;
                        periods_lat_q <= cfg_periods;
                        period_cnt    <= '0;
                        pending_q     <= 1'b0;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        count     <= '0;
                        pending_q <= 1'b0;
                    end else if (tc) begin
                        count      <= '0;
                        period_cnt <= period_inc;
                        if (pending_q || cfg_ok) begin
                            active_mod <= next_mod;
                            pending_q  <= 1'b0;
                        end
                        if (last_period) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                        if (cfg_ok) begin
                            pending_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    count   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    count   <= '0;
                end
            endcase
        end
    end

endmodule
